// File: rtl/ccp_dual_push_rr_sched.sv
// Round-robin scheduler feeding the CCP dual-write-port queue: up to two grants per cycle,
// occupancy tracking against overflow/underflow, and a drain handshake.
module ccp_dual_push_rr_sched #(
  parameter int NUM_REQ     = 4,
  parameter int MEM_W       = 4,
  parameter int QUEUE_DEPTH = 4,
  parameter int CNT_W       = $clog2(QUEUE_DEPTH + 1),
  parameter int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*MEM_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     pop,
  output logic                     push_1,
  output logic [MEM_W-1:0]         data_in_1,
  output logic                     push_2,
  output logic [MEM_W-1:0]         data_in_2,
  output logic [CNT_W-1:0]         occupancy,
  output logic                     q_empty,
  output logic                     q_full,
  input  logic                     drain_req,
  output logic                     drain_done,
  output logic                     pop_err
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t           state, state_next;
  logic             drain_done_next;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_next, g1, g2, last_idx;
  logic [IDX_W:0]   cand;
  logic             g1_found, g2_found, grant_1, grant_2;
  logic [1:0]       gmax, npush;
  logic             popv;
  logic [MEM_W-1:0] req_word [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_word[gi] = req_data[gi*MEM_W +: MEM_W];
  end

  // Same-cycle pop is deliberately not credited, so pop never reaches the grant logic.
  always_comb begin
    gmax = 2'd0;
    if (reset_n && state == RUN && !drain_req) begin
      if (int'(occupancy) + 2 <= QUEUE_DEPTH)      gmax = 2'd2;
      else if (int'(occupancy) + 1 <= QUEUE_DEPTH) gmax = 2'd1;
    end
  end

  // Circular scan from rr_ptr: first valid is the older grant, second valid the younger.
  always_comb begin
    g1_found = 1'b0;
    g2_found = 1'b0;
    g1       = '0;
    g2       = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (req_valid[cand[IDX_W-1:0]]) begin
        if (!g1_found) begin
          g1_found = 1'b1;
          g1       = cand[IDX_W-1:0];
        end else if (!g2_found) begin
          g2_found = 1'b1;
          g2       = cand[IDX_W-1:0];
        end
      end
    end
  end

  assign grant_1 = g1_found && (gmax != 2'd0);
  assign grant_2 = g2_found && (gmax == 2'd2);

  always_comb begin
    req_ready = '0;
    if (grant_1) req_ready[g1] = 1'b1;
    if (grant_2) req_ready[g2] = 1'b1;
  end

  assign push_1    = grant_1;
  assign push_2    = grant_2;
  assign data_in_1 = grant_1 ? req_word[g1] : '0;
  assign data_in_2 = grant_2 ? req_word[g2] : '0;

  always_comb begin
    last_idx    = grant_2 ? g2 : g1;
    rr_ptr_next = rr_ptr;
    if (grant_1) begin
      if (last_idx == IDX_W'(NUM_REQ - 1)) rr_ptr_next = '0;
      else                                 rr_ptr_next = last_idx + 1'b1;
    end
  end

  // A pop with an empty queue still succeeds when a push bypasses into it this cycle.
  assign npush = {1'b0, grant_1} + {1'b0, grant_2};
  assign popv  = pop && (occupancy != '0 || grant_1);

  always_comb begin
    state_next      = state;
    drain_done_next = 1'b0;
    case (state)
      RUN:   if (drain_req) state_next = DRAIN;
      DRAIN: if (occupancy == '0) begin
        state_next      = RUN;
        drain_done_next = 1'b1;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      rr_ptr     <= '0;
      occupancy  <= '0;
      drain_done <= 1'b0;
      pop_err    <= 1'b0;
    end else begin
      state      <= state_next;
      rr_ptr     <= rr_ptr_next;
      occupancy  <= occupancy + CNT_W'(npush) - CNT_W'(popv);
      drain_done <= drain_done_next;
      if (pop && occupancy == '0 && npush == 2'd0) pop_err <= 1'b1;
    end
  end

  assign q_empty = (occupancy == '0);
  assign q_full  = (occupancy == CNT_W'(QUEUE_DEPTH));

endmodule

// File: tb/tb_ccp_dual_push_rr_sched.sv
// Directed bench for ccp_dual_push_rr_sched: a queue-level reference model checked every
// cycle, plus literal expectations for the scenarios of interest.
module tb_ccp_dual_push_rr_sched;

  localparam int N  = 4;
  localparam int MW = 4;
  localparam int QD = 4;
  localparam int CW = $clog2(QD + 1);

  logic            clk;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N*MW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            pop;
  logic            push_1, push_2;
  logic [MW-1:0]   data_in_1, data_in_2;
  logic [CW-1:0]   occupancy;
  logic            q_empty, q_full;
  logic            drain_req, drain_done, pop_err;

  int checks = 0;
  int errors = 0;

  logic [MW-1:0] tb_data [N] = '{4'h9, 4'h6, 4'hC, 4'h3};

  ccp_dual_push_rr_sched #(
    .NUM_REQ(N), .MEM_W(MW), .QUEUE_DEPTH(QD)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .pop(pop),
    .push_1(push_1), .data_in_1(data_in_1),
    .push_2(push_2), .data_in_2(data_in_2),
    .occupancy(occupancy), .q_empty(q_empty), .q_full(q_full),
    .drain_req(drain_req), .drain_done(drain_done), .pop_err(pop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy as a count, requesters as a rotating priority list.
  int            m_occ, m_ptr, cap, ngr, idx;
  bit            m_drain, m_done, m_err, done_next;
  int            vq[$];
  logic [N-1:0]  exp_ready;
  logic          exp_p1, exp_p2;
  logic [MW-1:0] exp_d1, exp_d2;

  always @(negedge clk) begin
    if (!reset_n) begin
      m_occ = 0; m_ptr = 0; m_drain = 0; m_done = 0; m_err = 0;
    end
    if (!reset_n || m_drain || drain_req) cap = 0;
    else cap = (QD - m_occ < 2) ? QD - m_occ : 2;
    vq.delete();
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (req_valid[idx]) vq.push_back(idx);
    end
    ngr = (cap < vq.size()) ? cap : vq.size();
    exp_ready = '0; exp_p1 = 0; exp_p2 = 0; exp_d1 = '0; exp_d2 = '0;
    if (ngr >= 1) begin exp_ready[vq[0]] = 1'b1; exp_p1 = 1; exp_d1 = tb_data[vq[0]]; end
    if (ngr == 2) begin exp_ready[vq[1]] = 1'b1; exp_p2 = 1; exp_d2 = tb_data[vq[1]]; end

    checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    checkOutput("push_1", 32'(push_1), 32'(exp_p1));
    checkOutput("data_in_1", 32'(data_in_1), 32'(exp_d1));
    checkOutput("push_2", 32'(push_2), 32'(exp_p2));
    checkOutput("data_in_2", 32'(data_in_2), 32'(exp_d2));
    checkOutput("occupancy", 32'(occupancy), 32'(m_occ));
    checkOutput("q_empty", 32'(q_empty), 32'(m_occ == 0));
    checkOutput("q_full", 32'(q_full), 32'(m_occ == QD));
    checkOutput("drain_done", 32'(drain_done), 32'(m_done));
    checkOutput("pop_err", 32'(pop_err), 32'(m_err));

    if (reset_n) begin
      if (pop && m_occ == 0 && ngr == 0) m_err = 1;
      done_next = m_drain && (m_occ == 0);
      if (m_drain) m_drain = (m_occ != 0);
      else         m_drain = drain_req;
      m_done = done_next;
      m_occ = m_occ + ngr - ((pop && (m_occ + ngr > 0)) ? 1 : 0);
      if (ngr > 0) m_ptr = (vq[ngr-1] + 1) % N;
    end
  end

  task automatic applyStimulus(input logic [N-1:0] v, input logic p, input logic d);
    @(posedge clk);
    #1;
    req_valid = v;
    pop       = p;
    drain_req = d;
    @(negedge clk);
    #1;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    reset_n   = 1'b0;
    req_valid = 4'b1111;
    pop       = 1'b1;
    drain_req = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("reset req_ready", 32'(req_ready), 32'h0);
    checkOutput("reset push_1", 32'(push_1), 32'h0);
    @(posedge clk);
    #1;
    req_valid = '0;
    pop       = 1'b0;
    reset_n   = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = {tb_data[3], tb_data[2], tb_data[1], tb_data[0]};
    pop       = 1'b0;
    drain_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset occupancy", 32'(occupancy), 32'h0);
    checkOutput("reset q_empty", 32'(q_empty), 32'h1);
    reset_n = 1'b1;

    // All four valid: two pairs fill the queue, then nothing is granted.
    applyStimulus(4'b1111, 1'b0, 1'b0);
    checkOutput("t1 c0 ready", 32'(req_ready), 32'h3);
    checkOutput("t1 c0 d1", 32'(data_in_1), 32'h9);
    checkOutput("t1 c0 d2", 32'(data_in_2), 32'h6);
    applyStimulus(4'b1111, 1'b0, 1'b0);
    checkOutput("t1 c1 ready", 32'(req_ready), 32'hC);
    checkOutput("t1 c1 occ", 32'(occupancy), 32'd2);
    applyStimulus(4'b1111, 1'b0, 1'b0);
    checkOutput("t1 full ready", 32'(req_ready), 32'h0);
    checkOutput("t1 occ", 32'(occupancy), 32'd4);
    checkOutput("t1 q_full", 32'(q_full), 32'h1);

    // One slot free: only req0 fits; a pop while full frees the slot without a grant.
    applyStimulus(4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0011, 1'b0, 1'b0);
    checkOutput("t3 occ", 32'(occupancy), 32'd3);
    checkOutput("t3 ready", 32'(req_ready), 32'h1);
    checkOutput("t3 push_2", 32'(push_2), 32'h0);
    applyStimulus(4'b0010, 1'b1, 1'b0);
    checkOutput("t3 full ready", 32'(req_ready), 32'h0);
    checkOutput("t3 full occ", 32'(occupancy), 32'd4);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("t3 after pop", 32'(occupancy), 32'd3);

    // Drain from occupancy 2: grants masked until the pulse cycle.
    applyStimulus(4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0010, 1'b0, 1'b1);
    checkOutput("t5 occ", 32'(occupancy), 32'd2);
    checkOutput("t5 masked", 32'(req_ready), 32'h0);
    applyStimulus(4'b0010, 1'b1, 1'b0);
    checkOutput("t5 drain ready", 32'(req_ready), 32'h0);
    applyStimulus(4'b0010, 1'b1, 1'b0);
    applyStimulus(4'b0010, 1'b0, 1'b0);
    checkOutput("t5 empty", 32'(occupancy), 32'd0);
    checkOutput("t5 still masked", 32'(req_ready), 32'h0);
    checkOutput("t5 done early", 32'(drain_done), 32'h0);
    applyStimulus(4'b0010, 1'b0, 1'b0);
    checkOutput("t5 done pulse", 32'(drain_done), 32'h1);
    checkOutput("t5 resume", 32'(req_ready), 32'h2);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("t5 done clear", 32'(drain_done), 32'h0);
    checkOutput("t5 occ after", 32'(occupancy), 32'd1);

    // Fresh reset: single requester behind rr_ptr, then pointer proof.
    doReset();
    applyStimulus(4'b0100, 1'b0, 1'b0);
    checkOutput("t2 push_1", 32'(push_1), 32'h1);
    checkOutput("t2 d1", 32'(data_in_1), 32'hC);
    checkOutput("t2 push_2", 32'(push_2), 32'h0);
    applyStimulus(4'b1001, 1'b0, 1'b0);
    checkOutput("t2 ptr3 ready", 32'(req_ready), 32'h9);
    checkOutput("t2 ptr3 d1", 32'(data_in_1), 32'h3);
    checkOutput("t2 ptr3 d2", 32'(data_in_2), 32'h9);

    // Empty-bypass: pop with two pushes into an empty queue.
    doReset();
    applyStimulus(4'b1010, 1'b1, 1'b0);
    checkOutput("t4 ready", 32'(req_ready), 32'hA);
    checkOutput("t4 d1", 32'(data_in_1), 32'h6);
    checkOutput("t4 d2", 32'(data_in_2), 32'h3);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("t4 occ", 32'(occupancy), 32'd1);
    checkOutput("t4 pop_err", 32'(pop_err), 32'h0);

    // Underflow attempt sets a sticky error; then reset out of DRAIN.
    applyStimulus(4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("t6 pop_err", 32'(pop_err), 32'h1);
    checkOutput("t6 occ", 32'(occupancy), 32'd0);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    checkOutput("t6 sticky", 32'(pop_err), 32'h1);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("t6 in drain occ", 32'(occupancy), 32'd1);
    doReset();
    checkOutput("t6 reset occ", 32'(occupancy), 32'd0);
    checkOutput("t6 reset pop_err", 32'(pop_err), 32'h0);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    checkOutput("t6 run ready", 32'(req_ready), 32'h4);
    checkOutput("t6 no pulse", 32'(drain_done), 32'h0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("t6 no pulse 2", 32'(drain_done), 32'h0);
    applyStimulus(4'b0000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
